// File: rtl/cic_pkg.sv
// Shared CIC definitions: default sample width, sample type and modulo subtraction.
package cic_pkg;

  localparam int unsigned CIC_BITS = 10;

  typedef logic [CIC_BITS-1:0] sample_t;

  // Modulo-2^CIC_BITS difference; integrator wrap-around cancels through this.
  function automatic sample_t wrap_sub(input sample_t a, input sample_t b);
    return CIC_BITS'(a - b);
  endfunction

endpackage

// File: rtl/cic_decimating_comb_if.sv
// Sample stream bus between the integrator chain and the decimating comb.
interface cic_decimating_comb_if
  import cic_pkg::*;
#(
  parameter int unsigned BITS = CIC_BITS
);

  logic [BITS-1:0] stream_in;
  logic            valid;
  logic [BITS-1:0] stream_out;
  logic            out_valid;
  logic            ready;

  modport master (
    output stream_in, valid,
    input  stream_out, out_valid, ready
  );

  modport slave (
    input  stream_in, valid,
    output stream_out, out_valid, ready
  );

endinterface

// File: rtl/comb_stage.sv
// One comb section at the decimated rate: y = x - x delayed by DELAY strobes.
module comb_stage
  import cic_pkg::*;
#(
  parameter int unsigned BITS  = CIC_BITS,
  parameter int unsigned DELAY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] x,
  input  logic            in_strb,
  output logic [BITS-1:0] y,
  output logic            out_strb
);

  logic [DELAY-1:0][BITS-1:0] r_dl;
  logic [BITS-1:0]            r_y;
  logic                       r_strb;

  // History only shifts on strobes, so DELAY counts decimated samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl   <= '0;
      r_y    <= '0;
      r_strb <= 1'b0;
    end else begin
      r_strb <= in_strb;
      if (in_strb) begin
        r_y     <= BITS'(x - r_dl[DELAY-1]);
        r_dl[0] <= x;
        for (int i = 1; i < int'(DELAY); i++) begin
          r_dl[i] <= r_dl[i-1];
        end
      end
    end
  end

  assign y        = r_y;
  assign out_strb = r_strb;

endmodule

// File: rtl/cic_decimating_comb.sv
// CIC decimator back end: picks every RATE-th valid sample and runs it through STAGES combs.
module cic_decimating_comb
  import cic_pkg::*;
#(
  parameter int unsigned BITS   = CIC_BITS,
  parameter int unsigned RATE   = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned DELAY  = 1
) (
  input logic                 clk,
  input logic                 rst,
  cic_decimating_comb_if.slave bus
);

  localparam int unsigned CNT_W = (RATE > 1) ? $clog2(RATE) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             w_d0;
  logic [BITS-1:0]  w_x [STAGES+1];
  logic             w_d [STAGES+1];

  assign w_d0 = bus.valid && (r_cnt == CNT_W'(RATE - 1));

  // Phase counter only moves on valid samples, so input gaps are transparent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.valid) begin
      if (w_d0) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Set on the same edge that raises out_valid so both appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
    end else if (w_d[STAGES-1]) begin
      r_ready <= 1'b1;
    end
  end

  assign w_x[0] = bus.stream_in;
  assign w_d[0] = w_d0;

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_comb
    comb_stage #(
      .BITS  (BITS),
      .DELAY (DELAY)
    ) u_comb_stage (
      .clk      (clk),
      .rst      (rst),
      .x        (w_x[g]),
      .in_strb  (w_d[g]),
      .y        (w_x[g+1]),
      .out_strb (w_d[g+1])
    );
  end

  assign bus.stream_out = w_x[STAGES];
  assign bus.out_valid  = w_d[STAGES];
  assign bus.ready      = r_ready;

endmodule
